// File: rtl/seg7_scan_decoder.sv
// Monitor for a multiplexed 2-digit 7-segment bus: it synchronises seg/an, debounces each digit's dwell,
// decodes the glyphs back to BCD and emits complete unidades/decenas frames with error, rollover and timeout flags.
module seg7_scan_decoder #(
  parameter              DISPLAY_TYPE   = "ANODE_COMMON",
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned FRAME_TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [7:0] an,
  output logic [3:0] unidades,
  output logic [3:0] decenas,
  output logic       valid,
  output logic       rollover,
  output logic       seg_error,
  output logic       timeout
);

  localparam bit          INV = (DISPLAY_TYPE == "ANODE_COMMON");
  localparam int unsigned CW  = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned TW  = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic {COLLECT, COMMIT} state_t;

  logic [6:0]    seg_s1, seg_s2;
  logic [7:0]    an_s1, an_s2;
  logic [6:0]    seg_act;
  logic [7:0]    an_act;
  logic          idx_ok;
  logic [8:0]    tup, prev_tup;
  logic [CW-1:0] cnt;
  logic          cap_v, cap_idx;
  logic [6:0]    cap_seg;
  logic [TW-1:0] tcnt;
  logic [4:0]    dec;
  logic [3:0]    u_bcd, d_bcd;
  logic          u_fresh, d_fresh;
  state_t        state;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = {1'b1, 4'd0};
      7'h06: decode = {1'b1, 4'd1};
      7'h5B: decode = {1'b1, 4'd2};
      7'h4F: decode = {1'b1, 4'd3};
      7'h66: decode = {1'b1, 4'd4};
      7'h6D: decode = {1'b1, 4'd5};
      7'h7D: decode = {1'b1, 4'd6};
      7'h07: decode = {1'b1, 4'd7};
      7'h7F: decode = {1'b1, 4'd8};
      7'h6F: decode = {1'b1, 4'd9};
      default: decode = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

  // Idle (no single digit selected) collapses to an all-zero tuple that is never captured.
  always_comb begin
    seg_act = INV ? ~seg_s2 : seg_s2;
    an_act  = INV ? ~an_s2 : an_s2;
    idx_ok  = (an_act[7:2] == '0) && (an_act[0] ^ an_act[1]);
    tup     = idx_ok ? {1'b1, an_act[1], seg_act} : '0;
    dec     = decode(cap_seg);
    timeout = (tcnt == TW'(FRAME_TIMEOUT));
  end

  // Down-counter reaches zero on the STABLE_SAMPLES-th identical sample, then stays there until the tuple moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_tup <= '0;
      cnt      <= '0;
      cap_v    <= 1'b0;
      cap_idx  <= 1'b0;
      cap_seg  <= '0;
    end else begin
      cap_v <= 1'b0;
      if (tup != prev_tup) begin
        prev_tup <= tup;
        cnt      <= CW'(STABLE_SAMPLES - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1) && prev_tup[8]) begin
          cap_v   <= 1'b1;
          cap_idx <= prev_tup[7];
          cap_seg <= prev_tup[6:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (cap_v) begin
      tcnt <= '0;
    end else if (!timeout) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Capture handling comes last so a capture landing in COMMIT (or during timeout) stays fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= COLLECT;
      u_bcd     <= '0;
      d_bcd     <= '0;
      u_fresh   <= 1'b0;
      d_fresh   <= 1'b0;
      unidades  <= '0;
      decenas   <= '0;
      valid     <= 1'b0;
      rollover  <= 1'b0;
      seg_error <= 1'b0;
    end else begin
      valid     <= 1'b0;
      rollover  <= 1'b0;
      seg_error <= 1'b0;
      if (timeout || state == COMMIT) begin
        u_fresh <= 1'b0;
        d_fresh <= 1'b0;
      end
      case (state)
        COLLECT: begin
          if (u_fresh && d_fresh) begin
            state    <= COMMIT;
            unidades <= u_bcd;
            decenas  <= d_bcd;
            valid    <= 1'b1;
            rollover <= (decenas == 4'd9) && (unidades == 4'd9) &&
                        (d_bcd == 4'd0) && (u_bcd == 4'd0);
          end
        end
        COMMIT: state <= COLLECT;
        default: state <= COLLECT;
      endcase
      if (cap_v) begin
        if (dec[4]) begin
          if (cap_idx) begin
            d_bcd   <= dec[3:0];
            d_fresh <= 1'b1;
          end else begin
            u_bcd   <= dec[3:0];
            u_fresh <= 1'b1;
          end
        end else begin
          seg_error <= 1'b1;
          if (cap_idx) d_fresh <= 1'b0;
          else         u_fresh <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (common-anode, 4 stable samples, 50-cycle timeout);
// expected frames are queued when stimulus is driven and matched when valid pulses.
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic [7:0] an;
  logic [3:0] unidades, decenas;
  logic       valid, rollover, seg_error, timeout;

  typedef struct {
    logic [3:0] d;
    logic [3:0] u;
    logic       r;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     seg_err_cycles = 0;

  seg7_scan_decoder #(
    .DISPLAY_TYPE("ANODE_COMMON"),
    .STABLE_SAMPLES(4),
    .FRAME_TIMEOUT(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg(seg),
    .an(an),
    .unidades(unidades),
    .decenas(decenas),
    .valid(valid),
    .rollover(rollover),
    .seg_error(seg_error),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Active-high glyph in, inverted onto the common-anode pins.
  task automatic drive(input logic [7:0] a, input logic [6:0] s, input int unsigned n);
    an  = a;
    seg = ~s;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] d, input logic [3:0] u, input logic r);
    frame_t f;
    f.d = d;
    f.u = u;
    f.r = r;
    exp_q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (seg_error) seg_err_cycles++;
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          check("frame_decenas", decenas, f.d);
          check("frame_unidades", unidades, f.u);
          check("frame_rollover", rollover, f.r);
        end
      end else if (rollover) begin
        check("rollover_without_valid", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    an    = 8'hFF;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_unidades", unidades, 0);
    check("rst_decenas", decenas, 0);
    check("rst_valid", valid, 0);
    check("rst_rollover", rollover, 0);
    check("rst_seg_error", seg_error, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b1;

    // T1: reset with U fresh, then D alone must not complete a frame
    drive(8'hFE, 7'h06, 10);
    reset = 1'b0;
    @(negedge clk);
    check("t1_unidades", unidades, 0);
    check("t1_decenas", decenas, 0);
    check("t1_valid", valid, 0);
    check("t1_timeout", timeout, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(8'hFD, 7'h5B, 10);
    drive(8'hFF, 7'h00, 5);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // T2: frame 23 with exact latency from the completing glyph
    push(4'd2, 4'd3, 1'b0);
    drive(8'hFE, 7'h4F, 10);
    an  = 8'hFD;
    seg = ~7'h5B;
    repeat (7) @(negedge clk);
    check("t2_valid_early", valid, 0);
    @(negedge clk);
    check("t2_valid_on_time", valid, 1);
    check("t2_decenas", decenas, 2);
    check("t2_unidades", unidades, 3);
    repeat (2) @(negedge clk);
    drive(8'hFF, 7'h00, 5);

    // T3: short dwell is not captured; a later D-only capture must not form a frame
    drive(8'hFE, 7'h06, 3);
    drive(8'hFF, 7'h00, 5);
    drive(8'hFD, 7'h66, 10);
    drive(8'hFF, 7'h00, 5);
    check("t3_seg_error", seg_err_cycles, 0);

    // T4: undecodable glyph on U
    drive(8'hFE, 7'h49, 10);
    check("t4_seg_error_cycles", seg_err_cycles, 1);
    check("t4_unidades_kept", unidades, 3);
    drive(8'hFF, 7'h00, 5);

    // T5: both anodes active is ignored; pending D=4 then pairs with U=5
    drive(8'hFC, 7'h3F, 20);
    push(4'd4, 4'd5, 1'b0);
    drive(8'hFE, 7'h6D, 10);
    drive(8'hFF, 7'h00, 3);

    // T6: 99 then 00 raises rollover with the second frame
    push(4'd9, 4'd9, 1'b0);
    drive(8'hFE, 7'h6F, 10);
    drive(8'hFD, 7'h6F, 10);
    push(4'd0, 4'd0, 1'b1);
    drive(8'hFE, 7'h3F, 10);
    drive(8'hFD, 7'h3F, 10);

    drive(8'hFF, 7'h00, 30);
    check("t6_timeout_not_yet", timeout, 0);
    drive(8'hFF, 7'h00, 30);
    check("t6_timeout_set", timeout, 1);
    drive(8'hFE, 7'h06, 10);
    check("t6_timeout_cleared", timeout, 0);
    drive(8'hFF, 7'h00, 10);

    check("end_queue_empty", exp_q.size(), 0);
    check("end_seg_error_cycles", seg_err_cycles, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
